// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Pure declarations: no logic, no latency.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand-in / result-out valid-ready bundle for serial_subtractor.
// slave = the subtractor, master = the producer/consumer driving it.
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow, zero, negative
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow, zero, negative
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - borrowIn.
// Purely combinational, no handshake.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrowIn,
    output logic diff,
    output logic borrowOut
);
    assign diff      = a ^ b ^ borrowIn;
    assign borrowOut = (~a & b) | (~(a ^ b) & borrowIn);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first; result valid WIDTH cycles after accept, II = WIDTH+2.
// Result and flags hold while out_ready is low; no new operands accepted until DONE drains.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sub_state_t       state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             borrow_out_q;
    logic             overflow_q;
    logic             zero_q;
    logic             negative_q;
    logic             cell_diff;
    logic             cell_borrow;

    full_subtractor u_cell (
        .a         (a_sh_q[0]),
        .b         (b_sh_q[0]),
        .borrowIn  (borrow_q),
        .diff      (cell_diff),
        .borrowOut (cell_borrow)
    );

    // Result fills from the MSB side so that after WIDTH shifts bit 0 lands at bit 0.
    assign res_d = {cell_diff, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
            zero_q       <= 1'b0;
            negative_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh_q     <= bus.a;
                        b_sh_q     <= bus.b;
                        a_msb_q    <= bus.a[WIDTH-1];
                        b_msb_q    <= bus.b[WIDTH-1];
                        borrow_q   <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_q    <= res_d;
                    a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
                    borrow_q <= cell_borrow;
                    if (cnt_q == LAST_BIT) begin
                        // Flags taken from the combinational final bit, not the stale res_q.
                        state_q      <= DONE;
                        out_valid_q  <= 1'b1;
                        borrow_out_q <= cell_borrow;
                        overflow_q   <= (a_msb_q != b_msb_q) && (cell_diff != a_msb_q);
                        zero_q       <= (res_d == '0);
                        negative_q   <= cell_diff;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.diff       = res_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.overflow   = overflow_q;
    assign bus.zero       = zero_q;
    assign bus.negative   = negative_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock through a single full-subtractor cell with a registered borrow chain.
- Serves as the inverse-direction companion to the ripple adder datapath; trades latency for area in the FPGA lab designs.
- Operands arrive on a valid/ready input handshake. Results and flags leave on a valid/ready output handshake.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a/b present
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend (two's complement or unsigned)
b  input  WIDTH  subtrahend
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b modulo 2^WIDTH
borrow_out  output  1  unsigned borrow (1 when a < b unsigned)
overflow  output  1  signed overflow of a - b
zero  output  1  diff == 0
negative  output  1  diff[WIDTH-1]

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - Shift registers, bit counter and borrow register clear to 0.
  - Reset values: in_ready=1 once rst_n=1; out_valid=0; diff=0; borrow_out=0; overflow=0; zero=0; negative=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture a and b into internal shift registers, clear borrow register and bit counter, go to SHIFT.
  - Operands are never read again after capture.
- SHIFT:
  - in_ready=0; in_valid ignored.
  - Each edge:
    - Feed bit 0 of both shift registers plus the borrow register into the full_subtractor cell.
    - Shift the diff bit into the result register from the MSB side.
    - Right-shift the operand registers.
    - Update the borrow register.
    - Increment the counter.
  - On the edge processing bit WIDTH-1, go to DONE and assert out_valid.
  - Latency: out_valid is seen high exactly WIDTH cycles after the accepting edge.
- Flags are registered at the SHIFT->DONE edge:
  - borrow_out = final borrow.
  - overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]). Captured a[MSB]/b[MSB] are saved at accept for this.
  - zero = (diff == 0).
  - negative = diff[MSB].
- DONE:
  - out_valid=1. diff and flags are held stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - diff and flags keep their last value; they are don't-care while out_valid=0.
  - No same-cycle reload: the next operand accept happens at the earliest one edge after the DONE->IDLE edge. Minimum initiation interval is WIDTH+2 cycles.
- Reset mid-SHIFT or mid-DONE: the in-flight operation is discarded, no out_valid pulse occurs, and all outputs take their reset values immediately.
- Arithmetic is pure modulo 2^WIDTH. The same diff is correct for unsigned and two's-complement interpretation.
- The bit counter is clog2(WIDTH) bits wide and does not wrap during SHIFT.

Decomposition:
- Package serial_sub_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t
  - localparam DEFAULT_WIDTH = 8
- Sub-module full_subtractor is combinational:
  - Ports: a, b, borrowIn, diff, borrowOut.
  - diff = a ^ b ^ borrowIn.
  - borrowOut = (~a & b) | (~(a ^ b) & borrowIn).
  - Instantiated once. Tested standalone with an exhaustive 8-row truth table.

Test Plan:
1. WIDTH=8: a=0x5A, b=0x3C, out_ready=1 -> out_valid exactly 8 cycles after accept; diff=0x1E, borrow_out=0, overflow=0, zero=0, negative=0.
2. a=0x00, b=0x01 -> diff=0xFF, borrow_out=1, negative=1, overflow=0. Then a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrow_out=0, negative=0.
3. a=0x37, b=0x37 -> diff=0x00, zero=1, borrow_out=0. Change a/b on the input every cycle during SHIFT -> result unaffected.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> diff/flags stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> out_valid drops next edge; in_ready=1 the same cycle.
5. Assert rst_n=0 asynchronously after 3 SHIFT edges -> out_valid=0, in_ready=1 after release, no stray result. Next op a=0x10, b=0x20 -> diff=0xF0, borrow_out=1.
6. Back-to-back: in_valid held high with 4 operand pairs and out_ready=1 -> each accepted exactly WIDTH+2 cycles apart; results in order, all correct against a reference model.
